// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the PC sequencer.
//   state_t          : sequencer FSM states (BOOT, RUN, STALL)
//   WORD_BYTES       : bytes per instruction word (sequential PC step)
//   DEFAULT_RESET_PC : default fetch address loaded by reset
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc -- purely combinational next-address arithmetic.
// Ports:
//   pc     in  [31:0] current fetch address
//   offset in  [7:0]  signed word offset for jump/branch
//   seq4   out [31:0] pc + 4 (mod 2^32)
//   target out [31:0] seq4 + sign-extended offset * 4 (mod 2^32, silent wrap)
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [7:0]  offset,
  output logic [31:0] seq4,
  output logic [31:0] target
);

  logic [31:0] byte_offset;

  // Word offset -> byte offset: sign-extend and scale by WORD_BYTES (4).
  assign byte_offset = {{22{offset[7]}}, offset, 2'b00};
  assign seq4        = pc + WORD_BYTES;
  assign target      = seq4 + byte_offset;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter sequencer with stall handling and a
// one-entry pending-redirect register.
// Ports:
//   clk            in       system clock, rising edge
//   reset          in       synchronous active-high reset
//   busywait       in       memory busy: PC must hold
//   jump           in       unconditional relative jump request
//   branch_eq      in       branch request taken when zero=1
//   branch_ne      in       branch request taken when zero=0
//   zero           in       ALU zero flag of the current instruction
//   offset         in [7:0] signed word offset for jump/branch
//   pc             out[31:0] current fetch address (registered)
//   pc_valid       out      pc holds a fetchable address (registered)
//   redirect       out      one-cycle pulse after a taken redirect (registered)
//   dbg_state      out[1:0] current FSM state (state_t encoding)
//   dbg_pend_valid out      pending-redirect register valid bit
//
// Flow control: there is no valid/ready pair here. busywait is the only
// back-pressure; while it is high the PC holds and any taken request is
// parked in the pending register (first request wins) until release.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busywait,
  input  logic        jump,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic [7:0]  offset,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic [1:0]  dbg_state,
  output logic        dbg_pend_valid
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        redirect_q, redirect_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic [31:0] seq4;
  logic [31:0] target;
  logic        taken;

  pc_target_calc u_target_calc (
    .pc     (pc_q),
    .offset (offset),
    .seq4   (seq4),
    .target (target)
  );

  // Several requests at once still collapse to a single redirect to target.
  assign taken = jump | (branch_eq & zero) | (branch_ne & ~zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b0;
      redirect_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      redirect_q    <= redirect_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_valid_d    = pc_valid_q;
    redirect_d    = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    unique case (state_q)
      // One cycle with the reset PC marked invalid; requests are ignored.
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end

      RUN: begin
        pc_valid_d = 1'b1;
        if (busywait) begin
          state_d = STALL;
          if (taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = target;
          end
        end else begin
          pc_d       = taken ? target : seq4;
          redirect_d = taken;
        end
      end

      STALL: begin
        pc_valid_d = 1'b1;
        if (busywait) begin
          // Only an empty pending register accepts a request.
          if (taken && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_target_d = target;
          end
        end else begin
          state_d      = RUN;
          pend_valid_d = 1'b0;
          if (pend_valid_q) begin
            pc_d       = pend_target_q;
            redirect_d = 1'b1;
          end else if (taken) begin
            pc_d       = target;
            redirect_d = 1'b1;
          end else begin
            pc_d = seq4;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc             = pc_q;
  assign pc_valid       = pc_valid_q;
  assign redirect       = redirect_q;
  assign dbg_state      = state_q;
  assign dbg_pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer: a reference
// model predicts {pc_valid, redirect, pc} each cycle into a scoreboard
// queue, plus directed constant checks for the key scenarios.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        busywait;
  logic        jump;
  logic        branch_eq;
  logic        branch_ne;
  logic        zero;
  logic [7:0]  offset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic [1:0]  dbg_state;
  logic        dbg_pend_valid;

  int n_cmp;
  int n_err;

  // Scoreboard entries: {pc_valid, redirect, pc}.
  logic [33:0] exp_q[$];

  // Reference model state (0 boot, 1 run, 2 stall).
  int          m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_redir;
  logic        m_pv;
  logic [31:0] m_pt;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .busywait       (busywait),
    .jump           (jump),
    .branch_eq      (branch_eq),
    .branch_ne      (branch_ne),
    .zero           (zero),
    .offset         (offset),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .redirect       (redirect),
    .dbg_state      (dbg_state),
    .dbg_pend_valid (dbg_pend_valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic drive(input logic b, input logic j, input logic beq,
                       input logic bne, input logic z, input logic [7:0] off);
    busywait  = b;
    jump      = j;
    branch_eq = beq;
    branch_ne = bne;
    zero      = z;
    offset    = off;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Predict the next cycle from the current inputs, push it, clock, then
  // pop and compare against the DUT output.
  task automatic tick();
    logic [31:0] seq;
    logic [31:0] tgt;
    logic        tk;
    logic [33:0] exp_v;
    logic [33:0] obs_v;
    seq = m_pc + 32'd4;
    tgt = seq + {{22{offset[7]}}, offset, 2'b00};
    tk  = jump | (branch_eq & zero) | (branch_ne & ~zero);
    m_redir = 1'b0;
    if (reset) begin
      m_state = 0; m_pc = 32'h0; m_valid = 1'b0; m_pv = 1'b0; m_pt = 32'h0;
    end else if (m_state == 0) begin
      m_state = 1; m_valid = 1'b1;
    end else if (m_state == 1) begin
      if (busywait) begin
        m_state = 2;
        if (tk) begin m_pv = 1'b1; m_pt = tgt; end
      end else begin
        m_pc = tk ? tgt : seq;
        m_redir = tk;
      end
    end else begin
      if (busywait) begin
        if (tk && !m_pv) begin m_pv = 1'b1; m_pt = tgt; end
      end else begin
        if (m_pv) begin m_pc = m_pt; m_redir = 1'b1; end
        else if (tk) begin m_pc = tgt; m_redir = 1'b1; end
        else m_pc = seq;
        m_pv = 1'b0;
        m_state = 1;
      end
    end
    exp_q.push_back({m_valid, m_redir, m_pc});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = {pc_valid, redirect, pc};
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL scoreboard t=%0t got valid=%b redir=%b pc=%h expected valid=%b redir=%b pc=%h",
               $time, obs_v[33], obs_v[32], obs_v[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    n_cmp++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || redirect !== 1'b0 || dbg_pend_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got pc=%h valid=%b redir=%b pend=%b expected pc=0 valid=0 redir=0 pend=0",
               pc, pc_valid, redirect, dbg_pend_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    logic [31:0] exp_pc[3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin
        n_err++;
        $display("FAIL idle_seq[%0d] got pc=%h valid=%b expected pc=%h valid=1", i, pc, pc_valid, exp_pc[i]);
      end
    end
  endtask

  task automatic test_jump();
    idle();
    tick(); tick();                       // 0x0C, 0x10
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
    tick();
    n_cmp++;
    if (pc !== 32'h0C || redirect !== 1'b1) begin
      n_err++;
      $display("FAIL jump_back got pc=%h redir=%b expected pc=0000000c redir=1", pc, redirect);
    end
    idle();
    tick();
    n_cmp++;
    if (pc !== 32'h10 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL jump_pulse got pc=%h redir=%b expected pc=00000010 redir=0", pc, redirect);
    end
  endtask

  task automatic test_branch();
    idle();
    for (int i = 0; i < 4; i++) tick(); // 0x14 .. 0x20
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    tick();
    n_cmp++;
    if (pc !== 32'h24 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL beq_not_taken got pc=%h redir=%b expected pc=00000024 redir=0", pc, redirect);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
    tick();
    n_cmp++;
    if (pc !== 32'h34 || redirect !== 1'b1) begin
      n_err++;
      $display("FAIL bne_taken got pc=%h redir=%b expected pc=00000034 redir=1", pc, redirect);
    end
  endtask

  task automatic test_stall();
    idle();
    for (int i = 0; i < 3; i++) tick(); // 0x38, 0x3C, 0x40
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (pc !== 32'h40 || redirect !== 1'b0 || pc_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got pc=%h redir=%b valid=%b expected pc=00000040 redir=0 valid=1",
                 i, pc, redirect, pc_valid);
      end
    end
    idle();
    tick();
    n_cmp++;
    if (pc !== 32'h4C || redirect !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release got pc=%h redir=%b expected pc=0000004c redir=1", pc, redirect);
    end
    tick();                                // 0x50
    // First request wins: pend 0x50+4+8=0x5C, later offset ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0A); tick();
    idle();
    tick();
    n_cmp++;
    if (pc !== 32'h5C || redirect !== 1'b1) begin
      n_err++;
      $display("FAIL first_wins got pc=%h redir=%b expected pc=0000005c redir=1", pc, redirect);
    end
    // Stall with nothing pending, request arrives on the release edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01); tick();
    n_cmp++;
    if (pc !== 32'h64 || redirect !== 1'b1) begin
      n_err++;
      $display("FAIL release_taken got pc=%h redir=%b expected pc=00000064 redir=1", pc, redirect);
    end
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    tick();
    n_cmp++;
    if (dbg_pend_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pend_set got pend=%b expected 1", dbg_pend_valid);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || dbg_pend_valid !== 1'b0 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pending got pc=%h valid=%b pend=%b redir=%b expected pc=0 valid=0 pend=0 redir=0",
               pc, pc_valid, dbg_pend_valid, redirect);
    end
    reset = 1'b0;
    idle();
    tick();
    tick();
    n_cmp++;
    if (pc !== 32'h4 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset got pc=%h redir=%b expected pc=00000004 redir=0", pc, redirect);
    end
  endtask

  task automatic test_wrap();
    // From 0x4: 0x8 + (-3*4) = 0xFFFFFFFC.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD);
    tick();
    idle();
    tick();
    n_cmp++;
    if (pc !== 32'h0 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL wrap got pc=%h redir=%b expected pc=00000000 redir=0", pc, redirect);
    end
    // All requests at once: single redirect to 0x0 + 4 + 4.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01);
    tick();
    idle();
    tick();
    n_cmp++;
    if (pc !== 32'h0C || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL all_requests got pc=%h redir=%b expected pc=0000000c redir=0", pc, redirect);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
  endtask

  // ---------------- main ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    m_state = 0; m_pc = 32'h0; m_valid = 1'b0; m_redir = 1'b0; m_pv = 1'b0; m_pt = 32'h0;
    reset = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_idle();
    test_jump();
    test_branch();
    test_stall();
    test_reset_pending();
    test_wrap();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
